// File: rtl/traffic_request_frontend.sv
// Request front end for the traffic-light controller: synchronizes and debounces
// crosswalk buttons and emergency detectors, and latches requests until acknowledged.
module traffic_request_frontend #(
  parameter int NUM_LANES       = 8,
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int REQ_TIMEOUT     = 60
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] pedButton,
  input  logic [NUM_LANES-1:0] emgDetect,
  input  logic                 pedAck,
  input  logic                 emgAck,
  output logic                 pedSignal,
  output logic [NUM_LANES-1:0] pedPending,
  output logic                 emgSignal,
  output logic [NUM_LANES-1:0] emgLane,
  output logic                 timeoutFlag
);

  localparam int NB  = 2 * NUM_LANES;
  localparam int DCW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TCW = $clog2(REQ_TIMEOUT + 1);
  localparam logic [DCW-1:0] DEB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TCW-1:0] TO_MAX   = TCW'(REQ_TIMEOUT);
  localparam logic [TCW-1:0] TO_LAST  = TCW'(REQ_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} emg_state_e;

  logic [NB-1:0]        meta_q, meta_d;
  logic [NB-1:0]        sync_q, sync_d;
  logic [NB-1:0]        deb_q, deb_d;
  logic [DCW-1:0]       cnt_q [NB];
  logic [DCW-1:0]       cnt_d [NB];
  logic [NUM_LANES-1:0] ped_dly_q, ped_dly_d;
  logic [NUM_LANES-1:0] ped_pending_q, ped_pending_d;

  emg_state_e           state_q;
  logic                 emg_signal_q;
  logic [NUM_LANES-1:0] emg_lane_q;
  logic [TCW-1:0]       to_cnt_q;
  logic                 timeout_q;

  logic [NUM_LANES-1:0] ped_deb;
  logic [NUM_LANES-1:0] emg_deb;
  logic [NUM_LANES-1:0] emg_pick;
  logic                 lane_still_high;

  // Both request kinds share one synchronizer/debounce bank: pedestrians low, emergencies high.
  always_comb begin
    meta_d = {emgDetect, pedButton};
    sync_d = meta_q;
    deb_d  = deb_q;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = '0;
      if (sync_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_LAST) deb_d[i] = sync_q[i];
        else                      cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    ped_deb         = deb_q[NUM_LANES-1:0];
    emg_deb         = deb_q[NB-1:NUM_LANES];
    emg_pick        = emg_deb & (~emg_deb + 1'b1);
    lane_still_high = |(emg_deb & emg_lane_q);
    ped_dly_d       = ped_deb;
    // A fresh debounced press wins over a coincident acknowledge.
    ped_pending_d   = (pedAck ? '0 : ped_pending_q) | (ped_deb & ~ped_dly_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q        <= '0;
      sync_q        <= '0;
      deb_q         <= '0;
      ped_dly_q     <= '0;
      ped_pending_q <= '0;
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
    end else begin
      meta_q        <= meta_d;
      sync_q        <= sync_d;
      deb_q         <= deb_d;
      ped_dly_q     <= ped_dly_d;
      ped_pending_q <= ped_pending_d;
      for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      emg_signal_q <= 1'b0;
      emg_lane_q   <= '0;
      to_cnt_q     <= '0;
      timeout_q    <= 1'b0;
    end else begin
      if (emgAck) timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|emg_deb) begin
            emg_lane_q   <= emg_pick;
            emg_signal_q <= 1'b1;
            to_cnt_q     <= '0;
            state_q      <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (emgAck) begin
            state_q <= HOLD;
          end else if (!lane_still_high) begin
            emg_signal_q <= 1'b0;
            emg_lane_q   <= '0;
            state_q      <= IDLE;
          end else if (to_cnt_q != TO_MAX) begin
            to_cnt_q <= to_cnt_q + 1'b1;
            if (to_cnt_q == TO_LAST) timeout_q <= 1'b1;
          end
        end
        HOLD: begin
          if (!lane_still_high) begin
            emg_signal_q <= 1'b0;
            emg_lane_q   <= '0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pedPending  = ped_pending_q;
  assign pedSignal   = |ped_pending_q;
  assign emgSignal   = emg_signal_q;
  assign emgLane     = emg_lane_q;
  assign timeoutFlag = timeout_q;

endmodule

// File: tb/tb_traffic_request_frontend.sv
// Directed bench for traffic_request_frontend: a vector table plus hand-written
// sequences for bounce rejection, timeout and asynchronous reset.
module tb_traffic_request_frontend;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pb  = 8'h00;
  logic [7:0] ed  = 8'h00;
  logic       pa  = 1'b0;
  logic       ea  = 1'b0;
  logic       ped_signal;
  logic [7:0] ped_pending;
  logic       emg_signal;
  logic [7:0] emg_lane;
  logic       timeout_flag;

  int total = 0;
  int bad   = 0;

  traffic_request_frontend #(
    .NUM_LANES(8),
    .DEBOUNCE_CYCLES(3),
    .REQ_TIMEOUT(60)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pedButton(pb),
    .emgDetect(ed),
    .pedAck(pa),
    .emgAck(ea),
    .pedSignal(ped_signal),
    .pedPending(ped_pending),
    .emgSignal(emg_signal),
    .emgLane(emg_lane),
    .timeoutFlag(timeout_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pb;
    logic [7:0] ed;
    logic       pa;
    logic       ea;
    int         n;
    logic [7:0] pp;
    logic       ps;
    logic       es;
    logic [7:0] el;
    logic       tf;
  } vec_t;

  localparam int NV = 20;
  vec_t v [NV];

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [7:0] pp, input logic ps,
                         input logic es, input logic [7:0] el, input logic tf);
    chk({name, ".pedPending"}, ped_pending, pp);
    chk({name, ".pedSignal"}, {7'd0, ped_signal}, {7'd0, ps});
    chk({name, ".emgSignal"}, {7'd0, emg_signal}, {7'd0, es});
    chk({name, ".emgLane"}, emg_lane, el);
    chk({name, ".timeoutFlag"}, {7'd0, timeout_flag}, {7'd0, tf});
  endtask

  initial begin
    //        pb     ed     pa    ea    n   pp     ps    es    el     tf
    v[0]  = '{8'h00, 8'h00, 1'b0, 1'b0, 1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    v[1]  = '{8'h04, 8'h00, 1'b0, 1'b0, 5, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    v[2]  = '{8'h04, 8'h00, 1'b0, 1'b0, 1, 8'h04, 1'b1, 1'b0, 8'h00, 1'b0};
    v[3]  = '{8'h04, 8'h00, 1'b0, 1'b0, 3, 8'h04, 1'b1, 1'b0, 8'h00, 1'b0};
    v[4]  = '{8'h04, 8'h00, 1'b1, 1'b0, 1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    v[5]  = '{8'h04, 8'h00, 1'b0, 1'b0, 8, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    v[6]  = '{8'h00, 8'h00, 1'b0, 1'b0, 8, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    v[7]  = '{8'h00, 8'h0C, 1'b0, 1'b0, 5, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    v[8]  = '{8'h00, 8'h0C, 1'b0, 1'b0, 1, 8'h00, 1'b0, 1'b1, 8'h04, 1'b0};
    v[9]  = '{8'h00, 8'h08, 1'b0, 1'b0, 5, 8'h00, 1'b0, 1'b1, 8'h04, 1'b0};
    v[10] = '{8'h00, 8'h08, 1'b0, 1'b0, 1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    v[11] = '{8'h00, 8'h08, 1'b0, 1'b0, 1, 8'h00, 1'b0, 1'b1, 8'h08, 1'b0};
    v[12] = '{8'h00, 8'h00, 1'b0, 1'b0, 7, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    v[13] = '{8'h08, 8'h00, 1'b0, 1'b0, 6, 8'h08, 1'b1, 1'b0, 8'h00, 1'b0};
    v[14] = '{8'h09, 8'h00, 1'b0, 1'b0, 5, 8'h08, 1'b1, 1'b0, 8'h00, 1'b0};
    v[15] = '{8'h09, 8'h00, 1'b1, 1'b0, 1, 8'h01, 1'b1, 1'b0, 8'h00, 1'b0};
    v[16] = '{8'h00, 8'h00, 1'b0, 1'b0, 8, 8'h01, 1'b1, 1'b0, 8'h00, 1'b0};
    v[17] = '{8'h00, 8'h00, 1'b1, 1'b0, 1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    v[18] = '{8'h02, 8'h00, 1'b0, 1'b0, 2, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    v[19] = '{8'h00, 8'h00, 1'b0, 1'b0, 8, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};

    #2 rst = 1'b0;
    #10 chk_all("reset", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    #11 rst = 1'b1;
    tick_n(1);

    for (int i = 0; i < NV; i++) begin
      pb = v[i].pb;
      ed = v[i].ed;
      pa = v[i].pa;
      ea = v[i].ea;
      tick_n(1);
      pa = 1'b0;
      ea = 1'b0;
      if (v[i].n > 1) tick_n(v[i].n - 1);
      chk_all($sformatf("vec%0d", i), v[i].pp, v[i].ps, v[i].es, v[i].el, v[i].tf);
    end

    // Bouncing button: 2-cycle pulses must be rejected, then one request on a stable hold.
    for (int k = 0; k < 2; k++) begin
      pb = 8'h20;
      tick_n(2);
      chk_all($sformatf("bounce_hi%0d", k), 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      pb = 8'h00;
      tick_n(2);
      chk_all($sformatf("bounce_lo%0d", k), 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    end
    pb = 8'h20;
    tick_n(5);
    chk_all("bounce_hold5", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    tick_n(1);
    chk_all("bounce_hold6", 8'h20, 1'b1, 1'b0, 8'h00, 1'b0);
    pa = 1'b1;
    tick_n(1);
    pa = 1'b0;
    chk_all("bounce_ack", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    tick_n(6);
    chk_all("bounce_noreq", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    pb = 8'h00;
    tick_n(8);

    // Unacknowledged emergency on lane 1 runs into the timeout.
    ed = 8'h02;
    tick_n(6);
    chk_all("to_latch", 8'h00, 1'b0, 1'b1, 8'h02, 1'b0);
    tick_n(59);
    chk_all("to_edge59", 8'h00, 1'b0, 1'b1, 8'h02, 1'b0);
    tick_n(1);
    chk_all("to_edge60", 8'h00, 1'b0, 1'b1, 8'h02, 1'b1);
    tick_n(3);
    chk_all("to_sticky", 8'h00, 1'b0, 1'b1, 8'h02, 1'b1);
    ea = 1'b1;
    tick_n(1);
    ea = 1'b0;
    chk_all("to_ack", 8'h00, 1'b0, 1'b1, 8'h02, 1'b0);
    tick_n(10);
    chk_all("hold_stay", 8'h00, 1'b0, 1'b1, 8'h02, 1'b0);
    ed = 8'h00;
    tick_n(5);
    chk_all("hold_drop5", 8'h00, 1'b0, 1'b1, 8'h02, 1'b0);
    tick_n(1);
    chk_all("hold_drop6", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    tick_n(4);

    // Asynchronous reset between edges while a request is active.
    pb = 8'h01;
    ed = 8'h10;
    tick_n(6);
    chk_all("rst_pre", 8'h01, 1'b1, 1'b1, 8'h10, 1'b0);
    #3 rst = 1'b0;
    #1 chk_all("rst_async", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    pb = 8'h00;
    ed = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    tick_n(8);
    chk_all("rst_after", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
